// File: rtl/sim_status_reporter_pkg.sv
// Shared constants and state encoding for the simulation-status reporter.
package sim_status_pkg;

    localparam logic [1:0]  ADDR_REPORT          = 2'd0;
    localparam logic [1:0]  ADDR_FINISH          = 2'd1;
    localparam logic [1:0]  ADDR_KICK            = 2'd2;
    localparam logic [31:0] DEFAULT_TIMEOUT_CODE = 32'hDEAD_0001;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FINISHED
    } state_t;

endpackage

// File: rtl/sim_status_reporter_if.sv
// Register-write bus between firmware/stimulus and the status reporter.
interface sim_status_reporter_if;

    logic        bus_valid;
    logic        bus_ready;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;

    modport master (output bus_valid, output bus_addr, output bus_wdata, input  bus_ready);
    modport slave  (input  bus_valid, input  bus_addr, input  bus_wdata, output bus_ready);

endinterface

// File: rtl/sim_status_reporter_fifo.sv
// Synchronous DEPTH x 32 report FIFO; extra pointer MSB separates full from empty.
module sim_report_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] wdata,
    input  logic        pop,
    output logic [31:0] rdata,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + (AW+1)'(1);
            if (pop && !empty)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sim_status_reporter.sv
// Drives sim_done/sim_success/sim_report for CI: queues report words, drains
// them with a minimum hold time before completing, and forces a timeout if idle.
module sim_status_reporter
    import sim_status_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned HOLD_CYCLES  = 8,
    parameter int unsigned WDT_CYCLES   = 100000,
    parameter logic [31:0] TIMEOUT_CODE = DEFAULT_TIMEOUT_CODE
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    sim_status_reporter_if.slave  bus,
    output logic                  sim_success,
    output logic                  sim_done,
    output logic [31:0]           sim_report,
    output logic                  sim_report_stb,
    output logic                  fifo_overflow
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned WW = $clog2(WDT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [WW-1:0] WDT_LAST  = WW'(WDT_CYCLES - 1);
    localparam logic [WW-1:0] WDT_SAT   = WW'(WDT_CYCLES);

    state_t        state;
    logic [HW-1:0] hold;
    logic [WW-1:0] wdt;
    logic          pass;

    logic          active, accept, push, finish_wr, pop, expire, drained, to_finished;
    logic          fifo_full, fifo_empty;
    logic [31:0]   fifo_rdata;

    always_comb begin
        active         = (state != FINISHED);
        bus.bus_ready  = !active || (bus.bus_addr != ADDR_REPORT) || !fifo_full;
        accept         = bus.bus_valid && bus.bus_ready;
        push           = accept && active && (bus.bus_addr == ADDR_REPORT);
        finish_wr      = accept && active && (bus.bus_addr == ADDR_FINISH);
        pop            = active && (hold == '0) && !fifo_empty;
        expire         = active && !accept && (wdt == WDT_LAST);
        // A report arriving on the last drain cycle must still be shown.
        drained        = (state == DRAIN) && fifo_empty && (hold == '0) && !push;
        to_finished    = expire || drained;
    end

    sim_report_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (refclk),
        .rst_n (rst_n),
        .flush (expire),
        .push  (push),
        .wdata (bus.bus_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state          <= RUN;
            hold           <= '0;
            wdt            <= '0;
            pass           <= 1'b0;
            sim_success    <= 1'b0;
            sim_done       <= 1'b0;
            sim_report     <= '0;
            sim_report_stb <= 1'b0;
            fifo_overflow  <= 1'b0;
        end else begin
            sim_report_stb <= 1'b0;
            if (pop) begin
                sim_report     <= fifo_rdata;
                sim_report_stb <= 1'b1;
                hold           <= HOLD_LOAD;
            end else if (hold != '0) begin
                hold <= hold - HW'(1);
            end

            if (finish_wr)
                pass <= bus.bus_wdata[0];

            if (active)
                wdt <= accept ? '0 : (expire ? WDT_SAT : wdt + WW'(1));

            if (to_finished && bus.bus_valid && (bus.bus_addr == ADDR_REPORT) && fifo_full)
                fifo_overflow <= 1'b1;

            // Timeout overrides whatever the loader did this cycle.
            if (expire) begin
                state          <= FINISHED;
                sim_report     <= TIMEOUT_CODE;
                sim_report_stb <= 1'b1;
                hold           <= '0;
                sim_success    <= 1'b0;
                sim_done       <= 1'b1;
            end else if (drained) begin
                state       <= FINISHED;
                sim_done    <= 1'b1;
                sim_success <= finish_wr ? bus.bus_wdata[0] : pass;
            end else if ((state == RUN) && finish_wr) begin
                state <= DRAIN;
            end
        end
    end

endmodule
